// File: rtl/prn_gen_pkg.sv
// Shared constants and types for the PRN generator AXI4-Lite slave.
package prn_gen_pkg;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_SEED    = 2'd1;
  localparam logic [1:0] REG_POLY    = 2'd2;
  localparam logic [1:0] REG_NUM     = 2'd3;
  localparam int         CTRL_EN_BIT = 0;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;
endpackage

// File: rtl/prn_lfsr_core.sv
// Right-shifting Galois LFSR. The polynomial is captured at load time so
// register writes during a run do not disturb the sequence in flight.
module prn_lfsr_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         advance,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] poly,
  output logic [W-1:0] state
);
  logic [W-1:0] lfsr_q, lfsr_d, poly_q, poly_d;

  // Load the seed (zero would lock the LFSR, so it becomes 1) or step once.
  always_comb begin
    lfsr_d = lfsr_q;
    poly_d = poly_q;
    if (load) begin
      lfsr_d = (seed == '0) ? W'(1) : seed;
      poly_d = poly;
    end else if (advance) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? poly_q : '0);
    end
  end

  // LFSR state and latched polynomial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
      poly_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      poly_q <= poly_d;
    end
  end

  assign state = lfsr_q;
endmodule

// File: rtl/prn_gen_axil_slave.sv
// AXI4-Lite register file (CTRL/SEED/POLY/NUM_WORDS) driving an LFSR that
// streams NUM_WORDS pseudo-random words on an AXI4-Stream master port.
module prn_gen_axil_slave
  import prn_gen_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LFSR_WIDTH         = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [LFSR_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            busy,
  output logic                            done_irq
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  logic [3:0][DW-1:0] regs_q, regs_d;
  logic               awready_q, awready_d, bvalid_q, bvalid_d;
  logic               arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [DW-1:0]      count_q, count_d;
  logic               en_dly_q, en_dly_d, abort_q, abort_d, done_q, done_d;
  state_e             state_q, state_d;
  logic               wr_hs, rd_hs, en_rise, beat_hs, stall, lfsr_load;
  logic               unused_ok;

  assign wr_hs   = awready_q && s_axi_awvalid && s_axi_wvalid;
  assign rd_hs   = arready_q && s_axi_arvalid;
  assign en_rise = regs_q[REG_CTRL][CTRL_EN_BIT] && !en_dly_q;
  assign beat_hs = m_axis_tvalid && m_axis_tready;
  assign stall   = m_axis_tvalid && !m_axis_tready;

  // Write channel: one-cycle aw/w ready, byte-gated register update, held bvalid.
  always_comb begin
    awready_d = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
    bvalid_d  = wr_hs || (bvalid_q && !s_axi_bready);
    regs_d    = regs_q;
    if (wr_hs) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) regs_d[s_axi_awaddr[3:2]][8*b +: 8] = s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read channel: rdata sampled from the pre-write register image.
  always_comb begin
    arready_d = s_axi_arvalid && !rvalid_q && !arready_q;
    rvalid_d  = rd_hs || (rvalid_q && !s_axi_rready);
    rdata_d   = rd_hs ? regs_q[s_axi_araddr[3:2]] : rdata_q;
  end

  // Next-state logic for the run sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_rise) state_d = LOAD;
      LOAD:    state_d = (regs_q[REG_NUM] == '0) ? IDLE : RUN;
      RUN:     if (beat_hs && m_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    m_axis_tvalid = (state_q == RUN);
    m_axis_tlast  = (state_q == RUN) && ((count_q == DW'(1)) || abort_q);
    busy          = (state_q != IDLE);
    lfsr_load     = (state_q == LOAD);
  end

  // Beat counter, EN edge detect, abort flag and completion pulse.
  // abort follows !EN but is frozen while a beat is stalled so tlast never
  // changes under a pending beat; the first beat presented after EN drops
  // becomes the last one.
  always_comb begin
    en_dly_d = regs_q[REG_CTRL][CTRL_EN_BIT];
    count_d  = count_q;
    if (lfsr_load)    count_d = regs_q[REG_NUM];
    else if (beat_hs) count_d = count_q - DW'(1);
    if (state_q == IDLE) abort_d = 1'b0;
    else if (stall)      abort_d = abort_q;
    else                 abort_d = !regs_d[REG_CTRL][CTRL_EN_BIT];
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  // All control/status state.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      regs_q    <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      count_q   <= '0;
      en_dly_q  <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      state_q   <= IDLE;
    end else begin
      regs_q    <= regs_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      count_q   <= count_d;
      en_dly_q  <= en_dly_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      state_q   <= state_d;
    end
  end

  prn_lfsr_core #(.W(LFSR_WIDTH)) u_lfsr (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .load    (lfsr_load),
    .advance (beat_hs),
    .seed    (regs_q[REG_SEED]),
    .poly    (regs_q[REG_POLY]),
    .state   (m_axis_tdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign done_irq      = done_q;

  // Protection bits and sub-word address bits carry no meaning here.
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
endmodule
